// File: rtl/detector_jogada.sv
// detector_jogada: switch-input front end for the game FSM.
// Debounces the 4-bit `chaves` input and accepts a press only when exactly
// one switch is held. Each accepted press latches `jogada` and emits one
// `jogada_feita` strobe. A new play is not taken until all switches have
// been released and stayed released for DEBOUNCE_CYCLES cycles.
//
// Optional build macro JOGADA_PRIORIDADE_EN: a stable multi-bit press is
// resolved to its lowest-indexed set bit instead of being rejected, and
// `jogada_invalida` stays at 0.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       limpa,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       tem_jogada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    ESPERA       = 4'd0,
    FILTRA       = 4'd1,
    VALIDA       = 4'd2,
    SOLTA        = 4'd3,
    FILTRA_SOLTA = 4'd4
  } estado_t;

  // Terminal count of the stability counter; the counter stops here.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       amostra;

`ifdef JOGADA_PRIORIDADE_EN
  // Isolates the lowest-indexed set bit (two's-complement trick).
  function automatic logic [3:0] bit_menor(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction
`else
  // True when exactly one bit of v is set.
  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
`endif

  // The state code doubles as the debug display value; it is already a register.
  assign db_estado = estado;

  // Debounce FSM with registered play, strobes and activity flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= ESPERA;
      cnt             <= '0;
      amostra         <= '0;
      jogada          <= '0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      tem_jogada      <= 1'b0;
    end else begin
      // Strobes default low so they can only last the single VALIDA cycle.
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      tem_jogada      <= |chaves;

      // Clear first; an accept in VALIDA below overrides it on the same edge.
      if (limpa) begin
        jogada <= '0;
      end

      case (estado)
        ESPERA: begin
          if (habilita && (chaves != 4'd0)) begin
            amostra <= chaves;
            cnt     <= '0;
            estado  <= FILTRA;
          end
        end

        FILTRA: begin
          if (chaves == 4'd0) begin
            // Contact bounced open before the press settled.
            estado <= ESPERA;
          end else if (chaves != amostra) begin
            // Pattern still changing: restart the stability window.
            amostra <= chaves;
            cnt     <= '0;
          end else if (cnt == CNT_MAX) begin
            estado <= VALIDA;
          end else begin
            cnt <= cnt + CNT_UM;
          end
        end

        VALIDA: begin
`ifdef JOGADA_PRIORIDADE_EN
          jogada       <= bit_menor(amostra);
          jogada_feita <= 1'b1;
`else
          if (eh_one_hot(amostra)) begin
            jogada       <= amostra;
            jogada_feita <= 1'b1;
          end else begin
            jogada_invalida <= 1'b1;
          end
`endif
          cnt    <= '0;
          estado <= SOLTA;
        end

        SOLTA: begin
          if (chaves == 4'd0) begin
            cnt    <= '0;
            estado <= FILTRA_SOLTA;
          end
        end

        FILTRA_SOLTA: begin
          if (chaves != 4'd0) begin
            // Release bounced: keep waiting for a clean release.
            estado <= SOLTA;
          end else if (cnt == CNT_MAX) begin
            estado <= ESPERA;
          end else begin
            cnt <= cnt + CNT_UM;
          end
        end

        default: begin
          cnt    <= '0;
          estado <= ESPERA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed testbench for detector_jogada with default parameters.
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic       limpa;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic       tem_jogada;
  logic [3:0] db_estado;

  int n_chk;
  int n_err;

  detector_jogada #(
    .DEBOUNCE_CYCLES(3),
    .CNT_W          (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .limpa          (limpa),
    .chaves         (chaves),
    .jogada         (jogada),
    .jogada_feita   (jogada_feita),
    .jogada_invalida(jogada_invalida),
    .tem_jogada     (tem_jogada),
    .db_estado      (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are read 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold a value for n edges and record the strobes seen.
  task automatic hold(input logic [3:0] v, input int n,
                      output int nf, output int ni, output int idx_f);
    chaves = v;
    nf = 0;
    ni = 0;
    idx_f = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (jogada_feita) begin
        nf++;
        if (idx_f < 0) idx_f = i;
      end
      if (jogada_invalida) ni++;
    end
  endtask

  int nf, ni, idx;
  logic [3:0] est_log [0:9];
  logic [3:0] jog_seq [$];
  logic [3:0] prev_v;

  initial begin
    n_chk    = 0;
    n_err    = 0;
    reset    = 1'b1;
    habilita = 1'b0;
    limpa    = 1'b0;
    chaves   = 4'd0;

    // Reset state
    tick();
    chk("rst_jogada", jogada, 4'd0);
    chk("rst_feita", jogada_feita, 1'b0);
    chk("rst_invalida", jogada_invalida, 1'b0);
    chk("rst_tem", tem_jogada, 1'b0);
    chk("rst_estado", db_estado, 4'd0);
    reset = 1'b0;

    // Reset while filtering
    habilita = 1'b1;
    chaves   = 4'b0001;
    tick();
    chk("filtra_entry", db_estado, 4'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_estado", db_estado, 4'd0);
    chk("rst_mid_tem", tem_jogada, 1'b0);
    chk("rst_mid_jogada", jogada, 4'd0);
    reset  = 1'b0;
    chaves = 4'd0;
    tick();
    chk("rst_mid_idle", db_estado, 4'd0);

    // Clean press of 0010 held 10 cycles
    chk("clean_e_pre", db_estado, 4'd0);
    chaves = 4'b0010;
    nf = 0;
    idx = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      est_log[i] = db_estado;
      if (jogada_feita) begin
        nf++;
        if (idx < 0) idx = i;
      end
    end
    chk("clean_e0", est_log[0], 4'd1);
    chk("clean_e1", est_log[1], 4'd1);
    chk("clean_e2", est_log[2], 4'd1);
    chk("clean_e3", est_log[3], 4'd2);
    chk("clean_e4", est_log[4], 4'd3);
    chk("clean_e9", est_log[9], 4'd3);
    chk("clean_nfeita", nf, 1);
    chk("clean_idx", idx, 4);
    chk("clean_jogada", jogada, 4'b0010);

    // Release timing: SOLTA -> FILTRA_SOLTA -> ESPERA after 4 edges
    chaves = 4'd0;
    tick();
    tick();
    tick();
    chk("rel_fs", db_estado, 4'd4);
    tick();
    chk("rel_espera", db_estado, 4'd0);
    tick();

    // Invalid multi-bit press
    hold(4'b0101, 10, nf, ni, idx);
`ifdef JOGADA_PRIORIDADE_EN
    chk("inv_nfeita", nf, 1);
    chk("inv_ninval", ni, 0);
    chk("inv_jogada", jogada, 4'b0001);
`else
    chk("inv_nfeita", nf, 0);
    chk("inv_ninval", ni, 1);
    chk("inv_jogada", jogada, 4'b0010);
`endif
    chk("inv_idx_any", (nf + ni), 1);
    hold(4'd0, 6, nf, ni, idx);

    // Bounce on press, then stable
    nf = 0;
    ni = 0;
    for (int i = 0; i < 6; i++) begin
      chaves = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (jogada_feita || jogada_invalida) nf++;
    end
    chk("bounce_nostrobe", nf, 0);
    chk("bounce_state", db_estado, 4'd0);
    hold(4'b0001, 10, nf, ni, idx);
    chk("bounce_nfeita", nf, 1);
    chk("bounce_idx", idx, 4);
    chk("bounce_jogada", jogada, 4'b0001);
    // One-cycle release bounce must not re-trigger
    hold(4'd0, 1, nf, ni, idx);
    chk("relb_fs", db_estado, 4'd4);
    hold(4'b0001, 8, nf, ni, idx);
    chk("relb_nostrobe", nf + ni, 0);
    chk("relb_solta", db_estado, 4'd3);
    hold(4'd0, 6, nf, ni, idx);
    chk("relb_idle", db_estado, 4'd0);

    // Gating by habilita
    habilita = 1'b0;
    nf = 0;
    chaves = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (db_estado != 4'd0) nf++;
      if (jogada_feita || jogada_invalida) nf++;
    end
    chk("gate_idle", nf, 0);
    chk("gate_tem", tem_jogada, 1'b1);
    chaves   = 4'd0;
    habilita = 1'b1;
    tick();

    // limpa clears jogada
    limpa = 1'b1;
    tick();
    chk("limpa_jogada", jogada, 4'd0);
    chk("limpa_estado", db_estado, 4'd0);
    limpa = 1'b0;

    // limpa on the accept edge: accept wins
    chaves = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    chk("lacc_valida", db_estado, 4'd2);
    limpa = 1'b1;
    tick();
    chk("lacc_feita", jogada_feita, 1'b1);
    chk("lacc_jogada", jogada, 4'b0100);
    // limpa in SOLTA clears without touching state
    tick();
    chk("lsolta_jogada", jogada, 4'd0);
    chk("lsolta_estado", db_estado, 4'd3);
    chk("lsolta_feita", jogada_feita, 1'b0);
    limpa = 1'b0;
    hold(4'd0, 6, nf, ni, idx);

    // habilita dropping after first sample still completes the press
    chaves = 4'b1000;
    tick();
    habilita = 1'b0;
    hold(4'b1000, 6, nf, ni, idx);
    chk("hdrop_nfeita", nf, 1);
    chk("hdrop_jogada", jogada, 4'b1000);
    hold(4'd0, 6, nf, ni, idx);
    habilita = 1'b1;

    // Back-to-back plays with tem_jogada lag
    prev_v = 4'd0;
    jog_seq.delete();
    for (int s = 0; s < 5; s++) begin
      logic [3:0] v;
      case (s)
        0: v = 4'b0001;
        2: v = 4'b0010;
        4: v = 4'b0100;
        default: v = 4'b0000;
      endcase
      chaves = v;
      #1;
      chk("b2b_tem_lag", tem_jogada, |prev_v);
      for (int i = 0; i < 10; i++) begin
        tick();
        if (i == 0) chk("b2b_tem_new", tem_jogada, |v);
        if (jogada_feita) jog_seq.push_back(jogada);
      end
      prev_v = v;
    end
    chk("b2b_count", jog_seq.size(), 3);
    if (jog_seq.size() == 3) begin
      chk("b2b_p0", jog_seq[0], 4'b0001);
      chk("b2b_p1", jog_seq[1], 4'b0010);
      chk("b2b_p2", jog_seq[2], 4'b0100);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
